// File: rtl/stack_unit.sv
// Downward-growing LIFO with registered pop data, pointer load and occupancy count.
// Define STACK_GUARD_EN to block overflow/underflow and raise sticky ovf/unf flags.
module stack_unit #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_ld,
    input  logic [AW-1:0]    i_sp_in,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_vld,
    output logic [AW-1:0]    o_sp,
    output logic [AW:0]      o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf,
    output logic             o_unf
);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_sp;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;

    logic             w_empty;
    logic             w_full;
    logic             w_both;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    // Push+pop on an empty stack degrades to a plain push.
    assign w_both  = i_push & i_pop & ~w_empty;

`ifdef STACK_GUARD_EN
    assign w_push  = i_push & ~w_both & ~w_full;
    assign w_pop   = i_pop & ~i_push & ~w_empty;
`else
    assign w_push  = i_push & ~w_both;
    assign w_pop   = i_pop & ~i_push;
`endif

    assign w_wr_en   = ~i_rst & ~i_ld & (w_push | w_both);
    assign w_wr_addr = w_both ? r_sp : (r_sp - 1'b1);

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp       <= '0;
            r_count    <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= 1'b0;
            if (i_ld) begin
                r_sp    <= i_sp_in;
                r_count <= {1'b0, AW'(0) - i_sp_in};
            end else if (w_both) begin
                r_dout     <= r_mem[r_sp];
                r_dout_vld <= 1'b1;
            end else if (w_push) begin
                r_sp <= r_sp - 1'b1;
                // Without guarding, a push on a full stack overwrites the oldest entry.
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_dout     <= r_mem[r_sp];
                r_dout_vld <= 1'b1;
                r_sp       <= r_sp + 1'b1;
                if (!w_empty) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

`ifdef STACK_GUARD_EN
    logic r_ovf;
    logic r_unf;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = i_push & ~i_pop & w_full & ~i_ld;
    assign w_unf_set = i_pop & ~i_push & w_empty & ~i_ld;

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~i_clr_err);
            r_unf <= w_unf_set | (r_unf & ~i_clr_err);
        end
    end

    assign o_ovf = r_ovf;
    assign o_unf = r_unf;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr_err;
    assign o_ovf = 1'b0;
    assign o_unf = 1'b0;
`endif

    assign o_dout     = r_dout;
    assign o_dout_vld = r_dout_vld;
    assign o_sp       = r_sp;
    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_full     = w_full;

endmodule

// File: tb/tb_stack_unit.sv
// Randomized scoreboard bench for stack_unit against a queue/array reference model.
// Compile with +define+STACK_GUARD_EN to exercise the guarded configuration.
module tb_stack_unit;
    localparam int WIDTH = 10;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0, pop = 1'b0, ld = 1'b0, clr_err = 1'b0;
    logic [AW-1:0]    sp_in = '0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    sp;
    logic [AW:0]      count;
    logic             empty, full, ovf, unf;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_push(push), .i_pop(pop), .i_ld(ld),
        .i_sp_in(sp_in), .i_din(din), .i_clr_err(clr_err),
        .o_dout(dout), .o_dout_vld(dout_vld), .o_sp(sp), .o_count(count),
        .o_empty(empty), .o_full(full), .o_ovf(ovf), .o_unf(unf)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_mem [DEPTH];
    int m_sp, m_cnt, m_dout;
    bit m_vld, m_ovf, m_unf;
    int exp_q [$];
    bit mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input bit pu, input bit po,
                              input bit c, input int spin, input int d);
        bit set_o = 1'b0;
        bit set_u = 1'b0;
        m_vld = 1'b0;
        if (r) begin
            m_sp = 0; m_cnt = 0; m_dout = 0; m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        if (l) begin
            m_sp  = spin;
            m_cnt = (DEPTH - spin) % DEPTH;
        end else if (pu && po && m_cnt > 0) begin
            m_dout = m_mem[m_sp];
            m_mem[m_sp] = d;
            m_vld = 1'b1;
        end else if (pu) begin
            if (GUARD && m_cnt == DEPTH) begin
                set_o = 1'b1;
            end else begin
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
                m_mem[m_sp] = d;
                if (m_cnt < DEPTH) m_cnt++;
            end
        end else if (po) begin
            if (GUARD && m_cnt == 0) begin
                set_u = 1'b1;
            end else begin
                m_dout = m_mem[m_sp];
                m_vld = 1'b1;
                m_sp = (m_sp + 1) % DEPTH;
                if (m_cnt > 0) m_cnt--;
            end
        end
        if (GUARD) begin
            m_ovf = set_o | (m_ovf & !c);
            m_unf = set_u | (m_unf & !c);
        end
    endtask

    task automatic check_state();
        chk("sp", int'(sp), m_sp);
        chk("count", int'(count), m_cnt);
        chk("empty", int'(empty), int'(m_cnt == 0));
        chk("full", int'(full), int'(m_cnt == DEPTH));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("unf", int'(unf), int'(m_unf));
        chk("dout_vld", int'(dout_vld), int'(m_vld));
    endtask

    // Called right after a falling edge: drive, update model, clock, check.
    task automatic step(input bit r, input bit l, input bit pu, input bit po,
                        input bit c, input int spin, input int d);
        rst = r; ld = l; push = pu; pop = po; clr_err = c;
        sp_in = AW'(spin); din = WIDTH'(d);
        model_step(r, l, pu, po, c, spin, d);
        if (m_vld) exp_q.push_back(m_dout);
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: every dout_vld must match the oldest expected pop value.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && dout_vld) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dout_unexpected: got 0x%0h with no pop expected at %0t", dout, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(dout) != e) begin
                        n_fail++;
                        $display("FAIL dout: got 0x%0h expected 0x%0h at %0t", dout, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("rst_dout", int'(dout), 0);
        mon_en = 1'b1;

        // Fill every entry so later reads of any address are predictable.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, $urandom_range(0, (1 << WIDTH) - 1));
        chk("fill_full", int'(full), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h155);
        if (GUARD) chk("ovf_after_extra_push", int'(ovf), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("ovf_after_clr", int'(ovf), 0);

        // Pop straight after reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("pop_at_reset_sp", int'(sp), GUARD ? 0 : 1);
        chk("pop_at_reset_vld", int'(dout_vld), GUARD ? 0 : 1);

        // Three pushes then three pops
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h11);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h22);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h33);
        chk("sp_after_3_push", int'(sp), 'hFD);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("pop1", int'(dout), 'h33);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("pop2", int'(dout), 'h22);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("pop3", int'(dout), 'h11);
        chk("sp_after_pops", int'(sp), 0);

        // Replace the top with a simultaneous push and pop
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h11);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h22);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 'h3AA);
        chk("replace_dout", int'(dout), 'h22);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("after_replace_pop", int'(dout), 'h3AA);

        // Push and pop together on an empty stack acts as push only
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 'h2A5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

        // Load wins over push
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 'hF0, 'h1FF);
        chk("ld_count", int'(count), 16);

        // Reset during a push
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, $urandom_range(0, (1 << WIDTH) - 1));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h0AB);
        chk("rst_mid_push_count", int'(count), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, l, pu, po, c;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 39) == 0);
            c  = ($urandom_range(0, 7) == 0);
            pu = ($urandom_range(0, 1) == 1);
            po = ($urandom_range(0, 1) == 1);
            step(r, l, pu, po, c, $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, (1 << WIDTH) - 1));
        end

        idle();
        idle();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
